// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;

  // One 4-digit hex word as shown on the display.
  typedef logic [15:0] disp_word_t;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Number of requesters sharing the display.
  localparam int NUM_REQ = 2;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Request/ack handshake and display outputs of the arbiter.
// The arbiter is the slave; the requesters and the scan driver are the master side.
interface seg_display_arbiter_if;
  import seg_disp_pkg::*;

  logic [NUM_REQ-1:0] req;
  disp_word_t         data0;
  disp_word_t         data1;
  logic [NUM_REQ-1:0] ack;
  disp_word_t         disp_val;
  logic               disp_owner;
  logic               disp_active;
  logic               busy;

  modport master (
    output req, data0, data1,
    input  ack, disp_val, disp_owner, disp_active, busy
  );

  modport slave (
    input  req, data0, data1,
    output ack, disp_val, disp_owner, disp_active, busy
  );

endinterface

// File: rtl/seg_display_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: on contention the requester that
// was not served last wins; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] eff,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick a winner from the effective requests and the last-served index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (eff)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_idx   = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit seven-segment display between two requesters.
// A granted word is latched with a one-cycle ack and held for at least
// HOLD_CYCLES cycles before the next round-robin decision.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter  int HOLD_CYCLES = 1048576,
  localparam int CNT_W       = $clog2(HOLD_CYCLES) + 1
) (
  input  logic                  clk,
  input  logic                  clr,
  seg_display_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] ack_q;
  disp_word_t         val_q;
  logic               owner_q;
  logic               active_q;
  logic               busy_q;
  logic               last_q;

  logic [NUM_REQ-1:0] eff;
  logic               gnt_valid;
  logic               gnt_idx;
  logic               dwell;
  disp_word_t         gnt_word;

  // A requester is masked during its own ack cycle so a lingering req is
  // never granted twice for one word.
  assign eff      = bus.req & ~ack_q;
  assign dwell    = (state == HOLD) && (cnt != '0);
  assign gnt_word = gnt_idx ? bus.data1 : bus.data0;

  rr_arb2 u_rr_arb2 (
    .eff       (eff),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // FSM, dwell counter and all registered outputs; clr beats any grant.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      ack_q    <= '0;
      val_q    <= '0;
      owner_q  <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      ack_q <= '0;
      if (dwell) begin
        cnt    <= cnt - CNT_ONE;
        busy_q <= (cnt != CNT_ONE);
      end else if (gnt_valid) begin
        state          <= HOLD;
        cnt            <= CNT_LOAD;
        busy_q         <= (CNT_LOAD != '0);
        val_q          <= gnt_word;
        owner_q        <= gnt_idx;
        active_q       <= 1'b1;
        last_q         <= gnt_idx;
        ack_q[gnt_idx] <= 1'b1;
      end else begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.ack         = ack_q;
  assign bus.disp_val    = val_q;
  assign bus.disp_owner  = owner_q;
  assign bus.disp_active = active_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed testbench for seg_display_arbiter with HOLD_CYCLES=4.
module tb_seg_display_arbiter;

  localparam int HOLD = 4;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [1:0]  req;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  ack;
    logic [15:0] val;
    logic        owner;
    logic        active;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  // Inputs for one decision cycle; outputs are settled 1 ns after the edge.
  task automatic apply_stimulus(input logic c, input logic [1:0] r,
                                input logic [15:0] d0, input logic [15:0] d1);
    clr       = c;
    bus.req   = r;
    bus.data0 = d0;
    bus.data1 = d1;
    @(posedge clk);
    #1;
  endtask

  // One comparison against a bench-computed value.
  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic c, input logic [1:0] r,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [1:0] a, input logic [15:0] v,
                         input logic o, input logic act, input logic b);
    vec_t x;
    x.clr = c; x.req = r; x.d0 = d0; x.d1 = d1;
    x.ack = a; x.val = v; x.owner = o; x.active = act; x.busy = b;
    vecs.push_back(x);
  endtask

  task automatic check_all(input string tag, input logic [1:0] a,
                           input logic [15:0] v, input logic o,
                           input logic act, input logic b);
    check_output({tag, " ack"},    32'(bus.ack),         32'(a));
    check_output({tag, " val"},    32'(bus.disp_val),    32'(v));
    check_output({tag, " owner"},  32'(bus.disp_owner),  32'(o));
    check_output({tag, " active"}, 32'(bus.disp_active), 32'(act));
    check_output({tag, " busy"},   32'(bus.busy),        32'(b));
  endtask

  initial begin
    logic [1:0]  prev_ack;
    logic [15:0] exp_val;
    int          wait_cnt;
    bit          seen;

    checks = 0;
    errors = 0;
    clr = 1'b1;
    bus.req = 2'b00;
    bus.data0 = 16'h0000;
    bus.data1 = 16'h0000;

    //       clr req   d0       d1       ack    val      own act busy
    add_vec(1, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0);
    add_vec(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234, 0, 1, 1);
    add_vec(0, 2'b00, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 1, 1);
    add_vec(0, 2'b00, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 1, 1);
    add_vec(0, 2'b00, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 1, 0);
    add_vec(0, 2'b00, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 1, 0);
    // contention with last=0: requester 1 wins
    add_vec(0, 2'b11, 16'hAAAA, 16'h5555, 2'b10, 16'h5555, 1, 1, 1);
    add_vec(0, 2'b01, 16'hAAAA, 16'h0000, 2'b00, 16'h5555, 1, 1, 1);
    add_vec(0, 2'b01, 16'hAAAA, 16'h0000, 2'b00, 16'h5555, 1, 1, 1);
    add_vec(0, 2'b01, 16'hAAAA, 16'h0000, 2'b00, 16'h5555, 1, 1, 0);
    add_vec(0, 2'b01, 16'hAAAA, 16'h0000, 2'b01, 16'hAAAA, 0, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hAAAA, 0, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hAAAA, 0, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hAAAA, 0, 1, 0);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hAAAA, 0, 1, 0);
    // withdrawn request during dwell is never acked
    add_vec(0, 2'b10, 16'h0000, 16'hBEEF, 2'b10, 16'hBEEF, 1, 1, 1);
    add_vec(0, 2'b01, 16'hDEAD, 16'h0000, 2'b00, 16'hBEEF, 1, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hBEEF, 1, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hBEEF, 1, 1, 0);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hBEEF, 1, 1, 0);
    // reset mid-dwell, pending req[1] granted right after
    add_vec(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234, 0, 1, 1);
    add_vec(0, 2'b10, 16'h0000, 16'hCAFE, 2'b00, 16'h1234, 0, 1, 1);
    add_vec(1, 2'b10, 16'h0000, 16'hCAFE, 2'b00, 16'h0000, 0, 0, 0);
    add_vec(0, 2'b10, 16'h0000, 16'hCAFE, 2'b10, 16'hCAFE, 1, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hCAFE, 1, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hCAFE, 1, 1, 1);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hCAFE, 1, 1, 0);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'hCAFE, 1, 1, 0);
    // clr wins over a simultaneous grant
    add_vec(1, 2'b01, 16'h1234, 16'h0000, 2'b00, 16'h0000, 0, 0, 0);
    add_vec(0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].clr, vecs[i].req, vecs[i].d0, vecs[i].d1);
      check_all($sformatf("row%0d", i), vecs[i].ack, vecs[i].val,
                vecs[i].owner, vecs[i].active, vecs[i].busy);
    end

    // Ten idle cycles after reset keep everything at reset values.
    apply_stimulus(1'b1, 2'b00, 16'h0000, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 2'b00, 16'h0000, 16'h0000);
      check_all($sformatf("idle%0d", i), 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
    end

    // Simultaneous requests from reset: 0 first, 1 exactly HOLD cycles later.
    apply_stimulus(1'b1, 2'b00, 16'h0000, 16'h0000);
    apply_stimulus(1'b0, 2'b11, 16'hAAAA, 16'h5555);
    check_all("both first", 2'b01, 16'hAAAA, 1'b0, 1'b1, 1'b1);
    wait_cnt = 0;
    seen = 1'b0;
    while (!seen && wait_cnt < 8) begin
      apply_stimulus(1'b0, 2'b10, 16'h0000, 16'h5555);
      wait_cnt++;
      if (bus.ack != 2'b00) seen = 1'b1;
    end
    check_output("both second seen", 32'(seen), 32'd1);
    check_output("both second delay", 32'(wait_cnt), 32'(HOLD));
    check_all("both second", 2'b10, 16'h5555, 1'b1, 1'b1, 1'b1);

    // Continuous req[1] with changing data: grant every HOLD cycles.
    apply_stimulus(1'b1, 2'b00, 16'h0000, 16'h0000);
    prev_ack = 2'b00;
    for (int c = 0; c < 13; c++) begin
      apply_stimulus(1'b0, 2'b10, 16'h0000, 16'h1000 + 16'(c));
      exp_val = 16'h1000 + 16'(c - (c % HOLD));
      check_output($sformatf("stream%0d ack", c), 32'(bus.ack),
                   ((c % HOLD) == 0) ? 32'd2 : 32'd0);
      check_output($sformatf("stream%0d val", c), 32'(bus.disp_val), 32'(exp_val));
      check_output($sformatf("stream%0d consec", c), 32'(prev_ack & bus.ack), 32'd0);
      prev_ack = bus.ack;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares one 4-digit hex seven-segment display between two independent requesters (e.g. CPU status word and switch echo).
- Each requester posts a 16-bit word with a level request and receives a one-cycle ack when the word is latched.
- The arbiter holds each latched word on the display for a minimum dwell time, then re-arbitrates round-robin.
- Sits directly upstream of the seven-segment scan driver: disp_val feeds its 16-bit input.

Parameters:
HOLD_CYCLES, 1048576, minimum number of clk cycles a granted word stays on disp_val (>=1); default is about 10.5 ms at 100 MHz.
CNT_W, $clog2(HOLD_CYCLES)+1, dwell counter width (derived, not overridden).

Ports:
clk  input  1  system clock; single clock domain.
clr  input  1  synchronous, active-high reset.
req  input  2  level request; req[i] is held high until ack[i].
data0  input  16  word offered by requester 0; must be valid while req[0] is high.
data1  input  16  word offered by requester 1; must be valid while req[1] is high.
ack  output  2  one-cycle pulse; data of that requester latched on the same edge.
disp_val  output  16  word to display driver (4 hex nibbles).
disp_owner  output  1  index of the requester whose word is currently shown.
disp_active  output  1  high once any word has been latched since reset.
busy  output  1  high in HOLD with dwell counter nonzero.

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high. All outputs are registered.
- Reset values:
  - disp_val=16'h0000, disp_owner=0, disp_active=0, ack=2'b00, busy=0.
  - state=IDLE, cnt=0.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
- FSM states: IDLE, HOLD.
- Arbitration function (evaluated in IDLE, or in HOLD when cnt==0):
  - Effective request: eff[i] = req[i] & ~ack[i]. A requester is masked during its own ack cycle, so a lingering req is never double-granted.
  - If both eff bits are set, grant the index != last.
  - If exactly one is set, grant that index.
  - If none is set, there is no grant.
- On a grant to index g (registered at the end of the decision cycle):
  - disp_val<=data_g, disp_owner<=g, ack[g]<=1, last<=g, disp_active<=1.
  - cnt<=HOLD_CYCLES-1, state<=HOLD.
  - The grant takes 1 cycle: the decision in cycle T gives ack and the new disp_val in cycle T+1.
- In HOLD:
  - If cnt!=0: decrement cnt and ignore req.
  - If cnt==0: arbitrate. On a grant, proceed as above. With no grant, go to IDLE and keep disp_val/disp_owner unchanged; the display retains the last word.
- Dwell guarantee: disp_val is stable for at least HOLD_CYCLES cycles after each update.
  - HOLD_CYCLES=1 allows an update every cycle while alternating requesters.
- ack is a one-cycle pulse, so ack[i] is never high on two consecutive cycles for the same i.
  - Exception: back-to-back grants to the same requester when HOLD_CYCLES=1 and it re-raises req after the mask cycle.
- No preemption: a request arriving during the dwell waits; req must stay high until acked.
- Dropping req before ack is legal: the request is withdrawn and nothing is latched.
- Reset mid-operation:
  - Next edge returns to the reset values; the display clears to 0000.
  - A pending ack is lost and the requester must re-request.
  - clr has priority over any simultaneous grant.
- busy = (state==HOLD) && (cnt!=0).

Decomposition:
- Shared package seg_disp_pkg:
  - typedef logic [15:0] disp_word_t.
  - enum {IDLE, HOLD} arb_state_t.
  - Constant NUM_REQ=2.
- One natural sub-module, rr_arb2: purely combinational 2-way round-robin pick from eff and last.
  - Outputs gnt_valid and gnt_idx.
  - Reusable by other shared-peripheral controllers.
- The FSM, counter and output registers stay in seg_display_arbiter.

Test Plan (HOLD_CYCLES=4):
- Reset release, req=00 for 10 cycles -> disp_val=0000, disp_active=0, ack=00, busy=0 throughout.
- req[0]=1, data0=16'h1234 at cycle 0 -> ack=01 and disp_val=1234 at cycle 1, owner=0; busy cycles 1-3; req[0] dropped at cycle 1; state IDLE at cycle 5 with disp_val still 1234.
- req=11 simultaneously (data0=AAAA, data1=5555) from reset -> requester 0 acked at cycle 1; requester 1 acked exactly at cycle 5, disp_val=5555; 1234-style dwell holds 4 cycles.
- req[1] held continuously with data1 changing each cycle, req[0] idle -> ack[1] pulses every 4 cycles (cycles 1,5,9...), never on consecutive cycles; disp_val samples data1 at each grant-decision cycle.
- Assert clr at cycle 2 during the dwell of 1234 -> cycle 3 disp_val=0000, disp_active=0, ack=00; after clr drops, a pending req[1] is granted one cycle later.
- req[0] asserted at cycle 0 then dropped at cycle 0 end with arbiter in HOLD from a prior grant -> no ack[0] ever issued; the display keeps the prior word.
